// File: rtl/sim_i2c_pkg.sv
// rtl/sim_i2c_pkg.sv - shared types and constants for the virtual I2C target
// Purpose: FSM state enum, bit-counter width, ACK/NACK bus levels and the
//          open-drain pull helper used by sim_i2c_target.
package sim_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_tgt_state_e;

  // Counts 0..8 bits of the current byte.
  localparam int unsigned BitCntW = 4;

  localparam logic AckLevel  = 1'b0;
  localparam logic NackLevel = 1'b1;

  // Open-drain: presenting a 0 on the bus means pulling, a 1 means releasing.
  function automatic logic od_pull(logic level);
    return ~level;
  endfunction

endpackage

// File: rtl/sim_i2c_target_if.sv
// rtl/sim_i2c_target_if.sv - I2C pin bundle between the target and the bus top
// Purpose: resolved bus levels in, open-drain drives out.
// Signals: scl_i/sda_i resolved levels; sda_o/scl_o constant 0 data;
//          sda_en_o/scl_en_o pull enables (1 pulls the line low).
// Modports: slave = target side, master = bus/top side.
interface sim_i2c_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_o;
  logic sda_en_o;
  logic scl_o;
  logic scl_en_o;

  modport slave (
    input  scl_i, sda_i,
    output sda_o, sda_en_o, scl_o, scl_en_o
  );

  modport master (
    output scl_i, sda_i,
    input  sda_o, sda_en_o, scl_o, scl_en_o
  );
endinterface

// File: rtl/sim_i2c_sync_edge.sv
// rtl/sim_i2c_sync_edge.sv - 2-flop synchroniser with rise/fall detect
// Ports: clk_i, rst_ni (sync, active-low), in_i async level;
//        lvl_o synchronised level, rise_o/fall_o one-cycle edge strobes.
module sim_i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Reset to 1: an idle I2C line is pulled up, so no edge fires on release.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign lvl_o  = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/sim_i2c_target.sv
// rtl/sim_i2c_target.sv - simulation-only virtual I2C target with register file
// Purpose: decodes START/STOP, matches TargetAddr, serves NumRegs bytes with
//          an auto-incrementing pointer; drives SDA (and SCL when stretching)
//          open-drain.
// Ports: clk_i, rst_ni (sync, active-low); bus (sim_i2c_target_if.slave);
//        busy_o address-matched until STOP; wr_valid_o/wr_addr_o/wr_data_o
//        one-cycle register write report.
// Macro: SIM_I2C_TARGET_STRETCH_EN enables SCL stretching after ACK bits.
module sim_i2c_target
  import sim_i2c_pkg::*;
#(
  parameter logic [6:0]  TargetAddr    = 7'h50,
  parameter int          NumRegs       = 16,
  parameter int unsigned StretchCycles = 8,
  localparam int         PtrW          = $clog2(NumRegs)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  sim_i2c_target_if.slave     bus,
  output logic                busy_o,
  output logic                wr_valid_o,
  output logic [PtrW-1:0]     wr_addr_o,
  output logic [7:0]          wr_data_o
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  sim_i2c_sync_edge u_scl_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (bus.scl_i),
    .lvl_o  (scl_s),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  sim_i2c_sync_edge u_sda_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (bus.sda_i),
    .lvl_o  (sda_s),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  i2c_tgt_state_e     state_q, state_d;
  logic [BitCntW-1:0] cnt_q, cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         tx_q, tx_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic               rw_q, rw_d;
  logic               nack_q, nack_d;
  logic               sda_en_q, sda_en_d;
  logic               busy_q, busy_d;
  logic               wr_valid_d;
  logic [PtrW-1:0]    wr_addr_d;
  logic [7:0]         wr_data_d;
  logic               ack_end;
  logic [7:0]         regs_q [NumRegs];

  logic [7:0] rx_byte;
  logic       byte_done;
  assign rx_byte   = {shift_q[6:0], sda_s};
  assign byte_done = (cnt_q == BitCntW'(8));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    nack_d     = nack_q;
    sda_en_d   = sda_en_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_o;
    wr_data_d  = wr_data_o;
    ack_end    = 1'b0;

    // Bus conditions win over bit sampling and release SDA at once.
    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_en_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && !byte_done) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + BitCntW'(1);
            if (state_q == ST_WDATA && cnt_q == BitCntW'(7)) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
              ptr_d      = ptr_q + PtrW'(1);
            end
          end else if (scl_fall && byte_done) begin
            // The SCL fall after the 8th bit opens the ACK slot.
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == TargetAddr) begin
                state_d  = ST_ADDR_ACK;
                rw_d     = shift_q[0];
                busy_d   = 1'b1;
                sda_en_d = od_pull(AckLevel);
              end else begin
                state_d = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d    = shift_q[PtrW-1:0];
              state_d  = ST_PTR_ACK;
              sda_en_d = od_pull(AckLevel);
            end else begin
              state_d  = ST_WDATA_ACK;
              sda_en_d = od_pull(AckLevel);
            end
          end
        end

        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            ack_end  = 1'b1;
            cnt_d    = '0;
            sda_en_d = 1'b0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d  = ST_RDATA;
              tx_d     = regs_q[ptr_q];
              sda_en_d = od_pull(regs_q[ptr_q][7]);
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise && !byte_done) begin
            cnt_d = cnt_q + BitCntW'(1);
            if (cnt_q == BitCntW'(7)) begin
              ptr_d = ptr_q + PtrW'(1);
            end
          end else if (scl_fall && byte_done) begin
            // Hand SDA to the controller for its ACK/NACK.
            state_d  = ST_RDATA_ACK;
            sda_en_d = 1'b0;
          end else if (scl_fall && cnt_q != '0) begin
            sda_en_d = od_pull(tx_q[6]);
            tx_d     = {tx_q[6:0], 1'b0};
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            nack_d = (sda_s == NackLevel);
          end else if (scl_fall) begin
            ack_end = 1'b1;
            cnt_d   = '0;
            if (nack_q) begin
              state_d  = ST_IGNORE;
              sda_en_d = 1'b0;
            end else begin
              state_d  = ST_RDATA;
              tx_d     = regs_q[ptr_q];
              sda_en_d = od_pull(regs_q[ptr_q][7]);
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      sda_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      sda_en_q   <= sda_en_d;
      busy_q     <= busy_d;
      wr_valid_o <= wr_valid_d;
      wr_addr_o  <= wr_addr_d;
      wr_data_o  <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= 8'(i);
      end
    end else if (wr_valid_d) begin
      regs_q[wr_addr_d] <= wr_data_d;
    end
  end

`ifdef SIM_I2C_TARGET_STRETCH_EN
  localparam int unsigned StretchW = $clog2(StretchCycles + 1);
  logic [StretchW-1:0] stretch_q;

  // Hold SCL low for StretchCycles cycles from the fall that ends an ACK bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || stop_det || start_det) begin
      stretch_q <= '0;
    end else if (ack_end) begin
      stretch_q <= StretchW'(StretchCycles);
    end else if (stretch_q != '0) begin
      stretch_q <= stretch_q - StretchW'(1);
    end
  end

  assign bus.scl_en_o = (stretch_q != '0);
`else
  logic unused_stretch;
  assign unused_stretch = ^{StretchCycles, ack_end};
  assign bus.scl_en_o   = 1'b0;
`endif

  assign bus.sda_o    = 1'b0;
  assign bus.scl_o    = 1'b0;
  assign bus.sda_en_o = sda_en_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_sim_i2c_target.sv
// tb/tb_sim_i2c_target.sv - scoreboard bench for sim_i2c_target
module tb_sim_i2c_target;

  localparam int Q = 6;

  logic       clk;
  logic       rst_ni;
  logic       busy;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  logic c_scl, c_sda;
  logic scl_bus, sda_bus;

  sim_i2c_target_if i2c_bus ();

  assign scl_bus        = c_scl & ~i2c_bus.scl_en_o;
  assign sda_bus        = c_sda & ~i2c_bus.sda_en_o;
  assign i2c_bus.scl_i  = scl_bus;
  assign i2c_bus.sda_i  = sda_bus;

  sim_i2c_target dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .bus        (i2c_bus),
    .busy_o     (busy),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int n_checks;
  int n_errors;

  // Expected entries carry a valid bit on top so an empty queue never matches.
  logic [12:0] wr_exp [$];
  logic [9:0]  rx_exp [$];
  logic        rx_valid;
  logic [9:0]  rx_word;
  logic        seen_sda_en, seen_busy, seen_scl_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    int run = 0;
    logic [12:0] we;
    logic [9:0]  re;
    forever begin
      @(negedge clk);
      if (wr_valid) begin
        we = (wr_exp.size() != 0) ? wr_exp.pop_front() : 13'h0;
        check("wr_pulse", {1'b1, wr_addr, wr_data}, we);
      end
      if (rx_valid) begin
        re = (rx_exp.size() != 0) ? rx_exp.pop_front() : 10'h0;
        check("bus_rx", rx_word, re);
        rx_valid = 1'b0;
      end
      if (i2c_bus.sda_en_o) seen_sda_en = 1'b1;
      if (busy) seen_busy = 1'b1;
      if (i2c_bus.scl_en_o) begin
        seen_scl_en = 1'b1;
        run++;
      end else if (run != 0) begin
`ifdef SIM_I2C_TARGET_STRETCH_EN
        check("stretch_len", run, 8);
`endif
        run = 0;
      end
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_high();
    int k = 0;
    c_scl = 1'b1;
    while (!scl_bus && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (!scl_bus) check("scl_release_timeout", 0, 1);
  endtask

  task automatic start_cond();
    c_sda = 1'b1; hold(Q);
    scl_high();   hold(Q);
    c_sda = 1'b0; hold(Q);
    c_scl = 1'b0; hold(Q);
  endtask

  task automatic stop_cond();
    c_sda = 1'b0; hold(Q);
    scl_high();   hold(Q);
    c_sda = 1'b1; hold(Q);
  endtask

  task automatic bit_out(input logic b);
    c_sda = b;    hold(Q);
    scl_high();   hold(Q);
    c_scl = 1'b0; hold(Q);
  endtask

  task automatic bit_in(output logic b);
    c_sda = 1'b1; hold(Q);
    scl_high();   hold(Q);
    b = sda_bus;
    c_scl = 1'b0; hold(Q);
  endtask

  task automatic report(input logic tag, input logic [7:0] val);
    rx_word  = {1'b1, tag, val};
    rx_valid = 1'b1;
  endtask

  // exp_nack: 0 = target should ACK, 1 = no ACK.
  task automatic wr_byte(input logic [7:0] b, input logic exp_nack);
    logic a;
    rx_exp.push_back({1'b1, 1'b0, 7'h0, exp_nack});
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(a);
    report(1'b0, {7'h0, a});
  endtask

  // nack: 0 = controller ACKs the byte, 1 = controller NACKs.
  task automatic rd_byte(input logic [7:0] exp, input logic nack);
    logic [7:0] d = 8'h0;
    logic x;
    rx_exp.push_back({1'b1, 1'b1, exp});
    for (int i = 0; i < 8; i++) begin
      bit_in(x);
      d = {d[6:0], x};
    end
    report(1'b1, d);
    bit_out(nack);
  endtask

  initial begin
    logic [7:0] a0;
    n_checks = 0; n_errors = 0;
    rst_ni = 1'b0; c_scl = 1'b1; c_sda = 1'b1;
    rx_valid = 1'b0; rx_word = '0;
    seen_sda_en = 1'b0; seen_busy = 1'b0; seen_scl_en = 1'b0;
    fork
      monitor();
    join_none
    hold(5);
    check("rst_sda_en", i2c_bus.sda_en_o, 0);
    check("rst_scl_en", i2c_bus.scl_en_o, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("sda_o_const", i2c_bus.sda_o, 0);
    rst_ni = 1'b1;
    hold(10);

    // Write two bytes from pointer 3.
    wr_exp.push_back({1'b1, 4'h3, 8'h5A});
    wr_exp.push_back({1'b1, 4'h4, 8'hC3});
    start_cond();
    wr_byte(8'hA0, 1'b0);
    check("busy_after_match", busy, 1);
    wr_byte(8'h03, 1'b0);
    wr_byte(8'h5A, 1'b0);
    wr_byte(8'hC3, 1'b0);
    stop_cond();
    check("busy_after_stop", busy, 0);

    // Random read across the wrap point.
    start_cond();
    wr_byte(8'hA0, 1'b0);
    wr_byte(8'h0E, 1'b0);
    start_cond();
    wr_byte(8'hA1, 1'b0);
    rd_byte(8'h0E, 1'b0);
    rd_byte(8'h0F, 1'b0);
    rd_byte(8'h00, 1'b1);
    stop_cond();

    // Current-address read: pointer was left at 1.
    start_cond();
    wr_byte(8'hA1, 1'b0);
    rd_byte(8'h01, 1'b1);
    stop_cond();

    // Read back the written bytes.
    start_cond();
    wr_byte(8'hA0, 1'b0);
    wr_byte(8'h03, 1'b0);
    start_cond();
    wr_byte(8'hA1, 1'b0);
    rd_byte(8'h5A, 1'b0);
    rd_byte(8'hC3, 1'b1);
    stop_cond();

    // Address mismatch: 0xA2 is address 0x51.
    hold(4);
    seen_sda_en = 1'b0; seen_busy = 1'b0;
    start_cond();
    wr_byte(8'hA2, 1'b1);
    wr_byte(8'h55, 1'b1);
    stop_cond();
    check("mismatch_no_sda", seen_sda_en, 0);
    check("mismatch_no_busy", seen_busy, 0);

    // Abort a data byte after 4 bits, then a clean write.
    start_cond();
    wr_byte(8'hA0, 1'b0);
    wr_byte(8'h07, 1'b0);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    stop_cond();
    hold(4);
    check("abort_busy", busy, 0);
    wr_exp.push_back({1'b1, 4'h7, 8'h99});
    start_cond();
    wr_byte(8'hA0, 1'b0);
    wr_byte(8'h07, 1'b0);
    wr_byte(8'h99, 1'b0);
    stop_cond();

    // Reset while the target drives the address ACK.
    a0 = 8'hA0;
    start_cond();
    for (int i = 7; i >= 0; i--) bit_out(a0[i]);
    c_sda = 1'b1;
    hold(2);
    check("ack_driven", i2c_bus.sda_en_o, 1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("reset_release_sda", i2c_bus.sda_en_o, 0);
    check("reset_busy", busy, 0);
    hold(3);
    rst_ni = 1'b1;
    c_scl = 1'b1;
    hold(20);

    // Registers are back to reg[i] = i.
    start_cond();
    wr_byte(8'hA0, 1'b0);
    wr_byte(8'h03, 1'b0);
    start_cond();
    wr_byte(8'hA1, 1'b0);
    rd_byte(8'h03, 1'b0);
    rd_byte(8'h04, 1'b1);
    stop_cond();
    hold(10);

    check("wr_queue_drained", wr_exp.size(), 0);
    check("rx_queue_drained", rx_exp.size(), 0);
`ifndef SIM_I2C_TARGET_STRETCH_EN
    check("no_stretch", seen_scl_en, 0);
`else
    check("stretch_seen", seen_scl_en, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
